count_sequence_checker: RTL

COUNT_SEQUENCE_CHECKER -- requirements
Module: count_sequence_checker

---
 rtl/count_sequence_checker.sv | 130 +++++++++++++
 1 files changed

// File: rtl/count_sequence_checker.sv
// Tracks a sampled 2-bit up-counter, locks after a run of clean steps and keeps
// saturating error/wrap statistics while locked.
module count_sequence_checker #(
  parameter int unsigned LOCK_CNT    = 2,
  parameter int unsigned UNLOCK_ERRS = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cnt_in,
  input  logic             cnt_valid,
  output logic             locked,
  output logic             err_pulse,
  output logic             stalled,
  output logic [1:0]       expected,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  localparam int unsigned GW = $clog2(LOCK_CNT + 1);
  localparam int unsigned BW = $clog2(UNLOCK_ERRS + 1);

  typedef enum logic [1:0] {StIdle, StSync, StLocked} state_e;

  state_e           r_state, w_state_next;
  logic [1:0]       r_prev, w_prev_next;
  logic [GW-1:0]    r_good_run, w_good_run_next;
  logic [BW-1:0]    r_bad_run, w_bad_run_next;
  logic             r_err_pulse, w_err_pulse_next;
  logic             r_stalled, w_stalled_next;
  logic [CNT_W-1:0] r_err_count, w_err_count_next;
  logic [CNT_W-1:0] r_wrap_count, w_wrap_count_next;

  logic [1:0]       w_expected;
  logic             w_step;
  logic             w_repeat;
  logic [GW-1:0]    w_good_inc;
  logic [BW-1:0]    w_bad_inc;

  assign w_expected = r_prev + 2'd1;
  assign w_step     = (cnt_in == w_expected);
  assign w_repeat   = (cnt_in == r_prev);
  // Run counters never exceed their thresholds, so the increment fits.
  assign w_good_inc = r_good_run + GW'(1);
  assign w_bad_inc  = r_bad_run + BW'(1);

  always_comb begin
    w_state_next      = r_state;
    w_prev_next       = r_prev;
    w_good_run_next   = r_good_run;
    w_bad_run_next    = r_bad_run;
    w_err_pulse_next  = 1'b0;
    w_stalled_next    = r_stalled;
    w_err_count_next  = r_err_count;
    w_wrap_count_next = r_wrap_count;

    if (cnt_valid) begin
      w_prev_next = cnt_in;
      unique case (r_state)
        StIdle: begin
          w_good_run_next = '0;
          w_state_next    = StSync;
        end
        StSync: begin
          w_stalled_next = w_repeat;
          if (w_step) begin
            w_good_run_next = w_good_inc;
            if (w_good_inc == GW'(LOCK_CNT)) begin
              w_state_next   = StLocked;
              w_bad_run_next = '0;
            end
          end else if (!w_repeat) begin
            w_good_run_next = '0;
          end
        end
        StLocked: begin
          w_stalled_next = w_repeat;
          if (w_step) begin
            w_bad_run_next = '0;
            if (r_prev == 2'd3 && !(&r_wrap_count)) begin
              w_wrap_count_next = r_wrap_count + CNT_W'(1);
            end
          end else if (!w_repeat) begin
            // The unlocking sample still counts as an error.
            w_err_pulse_next = 1'b1;
            w_bad_run_next   = w_bad_inc;
            if (!(&r_err_count)) begin
              w_err_count_next = r_err_count + CNT_W'(1);
            end
            if (w_bad_inc == BW'(UNLOCK_ERRS)) begin
              w_state_next    = StSync;
              w_good_run_next = '0;
            end
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_prev       <= 2'd0;
      r_good_run   <= '0;
      r_bad_run    <= '0;
      r_err_pulse  <= 1'b0;
      r_stalled    <= 1'b0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_prev       <= w_prev_next;
      r_good_run   <= w_good_run_next;
      r_bad_run    <= w_bad_run_next;
      r_err_pulse  <= w_err_pulse_next;
      r_stalled    <= w_stalled_next;
      r_err_count  <= w_err_count_next;
      r_wrap_count <= w_wrap_count_next;
    end
  end

  assign locked     = (r_state == StLocked);
  assign err_pulse  = r_err_pulse;
  assign stalled    = r_stalled;
  assign expected   = w_expected;
  assign err_count  = r_err_count;
  assign wrap_count = r_wrap_count;

endmodule
